// File: rtl/phy_rx_pkg.sv
// Shared widths, un-stripe FSM encoding and default buffer depth for the phy_rx receive datapath.
package phy_rx_pkg;
    localparam int BYTE_W        = 8;
    localparam int WORD_W        = 32;
    localparam int BUF_DEPTH_DEF = 2;

    typedef enum logic {
        EXP_L0 = 1'b0,
        EXP_L1 = 1'b1
    } state_t;
endpackage

// File: rtl/mux_8_32.sv
// Per-lane byte collector (MSB-first 8->32) feeding a BUF_DEPTH-entry word FIFO.
module mux_8_32
    import phy_rx_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] data,
    input  logic              valid,
    input  logic              pop,
    output logic [WORD_W-1:0] word,
    output logic              empty,
    output logic              full,
    output logic              drop
);
    localparam int AW = $clog2(BUF_DEPTH);

    logic [1:0]               cnt;
    logic [WORD_W-BYTE_W-1:0] shreg;
    logic [WORD_W-1:0]        mem [BUF_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic                     complete;
    logic                     do_pop;
    logic                     push;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(BUF_DEPTH));
    assign complete = valid && (cnt == 2'd3);
    assign do_pop   = pop && !empty;
    // A full FIFO still takes the new word when a slot frees on the same edge.
    assign push     = complete && (!full || do_pop);
    assign drop     = complete && !push;
    assign word     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (valid)
                cnt <= cnt + 2'd1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Only the first three bytes are held; the fourth goes straight into the FIFO.
    always_ff @(posedge clk) begin
        if (valid && (cnt != 2'd3))
            shreg <= {shreg[WORD_W-2*BYTE_W-1:0], data};
        if (push)
            mem[wr_ptr] <= {shreg, data};
    end
endmodule

// File: rtl/phy_rx.sv
// Two-lane receive PHY: per-lane 8->32 collectors and a strict L0/L1 un-stripe stage.
// Optional sticky error flag (FIFO drop / lane skew) enabled by defining PHY_RX_ERR_EN.
module phy_rx
    import phy_rx_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in_0,
    input  logic              valid_in0,
    input  logic [BYTE_W-1:0] data_in_1,
    input  logic              valid_in1,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              err
);
    state_t            state;
    logic [WORD_W-1:0] word0, word1;
    logic              empty0, empty1;
    logic              full0, full1;
    logic              drop0, drop1;
    logic              pop0, pop1;

    assign pop0 = (state == EXP_L0) && !empty0;
    assign pop1 = (state == EXP_L1) && !empty1;

    mux_8_32 #(.BUF_DEPTH(BUF_DEPTH)) u_lane0 (
        .clk   (clk_4f),
        .rst_n (reset),
        .data  (data_in_0),
        .valid (valid_in0),
        .pop   (pop0),
        .word  (word0),
        .empty (empty0),
        .full  (full0),
        .drop  (drop0)
    );

    mux_8_32 #(.BUF_DEPTH(BUF_DEPTH)) u_lane1 (
        .clk   (clk_4f),
        .rst_n (reset),
        .data  (data_in_1),
        .valid (valid_in1),
        .pop   (pop1),
        .word  (word1),
        .empty (empty1),
        .full  (full1),
        .drop  (drop1)
    );

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state     <= EXP_L0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                EXP_L0: if (!empty0) begin
                    data_out  <= word0;
                    valid_out <= 1'b1;
                    state     <= EXP_L1;
                end
                EXP_L1: if (!empty1) begin
                    data_out  <= word1;
                    valid_out <= 1'b1;
                    state     <= EXP_L0;
                end
                default: state <= EXP_L0;
            endcase
        end
    end

`ifdef PHY_RX_ERR_EN
    logic err_q;

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset)
            err_q <= 1'b0;
        else if (drop0 || drop1 || (full0 && empty1) || (full1 && empty0))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic unused_err_src;

    assign unused_err_src = ^{drop0, drop1, full0, full1};
    assign err            = 1'b0;
`endif
endmodule

// File: tb/tb_phy_rx.sv
// Scoreboarded random + directed bench for phy_rx against a queue-based lane/FIFO model.
module tb_phy_rx;
    localparam int D = 2;

    logic        clk_4f    = 1'b0;
    logic        reset     = 1'b1;
    logic [7:0]  data_in_0 = '0;
    logic [7:0]  data_in_1 = '0;
    logic        valid_in0 = 1'b0;
    logic        valid_in1 = 1'b0;
    logic [31:0] data_out;
    logic        valid_out;
    logic        err;

    phy_rx #(.BUF_DEPTH(D)) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_in_0 (data_in_0),
        .valid_in0 (valid_in0),
        .data_in_1 (data_in_1),
        .valid_in1 (valid_in1),
        .data_out  (data_out),
        .valid_out (valid_out),
        .err       (err)
    );

    always #5 clk_4f = ~clk_4f;

    int edge_cnt = 0;
    always @(posedge clk_4f) edge_cnt++;

    typedef struct {
        logic [31:0] w;
        int          e;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  part0[$], part1[$];
    logic [31:0] q0[$], q1[$];
    logic [31:0] got[$];
    logic [31:0] mon_last = '0;
    bit          want_l1  = 1'b0;
    bit          err_m    = 1'b0;
    bit          mon_on   = 1'b0;
    int          n_cmp    = 0;
    int          n_bad    = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic bit err_exp();
`ifdef PHY_RX_ERR_EN
        return err_m;
`else
        return 1'b0;
`endif
    endfunction

    // Behaviour of the edge that samples these inputs: expected lane pops first, then words complete.
    function automatic void model_step(bit v0, logic [7:0] b0, bit v1, logic [7:0] b1, int e);
        exp_t t;
        bit   skew;
        bit   drop;
        skew = (q0.size() == D && q1.size() == 0) || (q1.size() == D && q0.size() == 0);
        drop = 1'b0;
        if (!want_l1 && q0.size() > 0) begin
            t.w = q0.pop_front(); t.e = e; sb.push_back(t); want_l1 = 1'b1;
        end else if (want_l1 && q1.size() > 0) begin
            t.w = q1.pop_front(); t.e = e; sb.push_back(t); want_l1 = 1'b0;
        end
        if (v0) begin
            part0.push_back(b0);
            if (part0.size() == 4) begin
                if (q0.size() < D) q0.push_back({part0[0], part0[1], part0[2], part0[3]});
                else drop = 1'b1;
                part0.delete();
            end
        end
        if (v1) begin
            part1.push_back(b1);
            if (part1.size() == 4) begin
                if (q1.size() < D) q1.push_back({part1[0], part1[1], part1[2], part1[3]});
                else drop = 1'b1;
                part1.delete();
            end
        end
        err_m = err_m | drop | skew;
    endfunction

    task automatic cyc(input bit v0, input logic [7:0] b0, input bit v1, input logic [7:0] b1);
        @(negedge clk_4f);
        valid_in0 = v0; data_in_0 = b0;
        valid_in1 = v1; data_in_1 = b1;
        model_step(v0, b0, v1, b1, edge_cnt + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk_4f);
        reset = 1'b0;
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        part0.delete(); part1.delete(); q0.delete(); q1.delete();
        sb.delete(); got.delete();
        mon_last = '0; want_l1 = 1'b0; err_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_4f);
            chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
            chk("reset_data_out", data_out, 32'd0);
            chk("reset_err", {31'd0, err}, 32'd0);
        end
        reset  = 1'b1;
        mon_on = 1'b1;
    endtask

    // Monitor: every cycle either an expected word lands on this edge or the output holds.
    always @(negedge clk_4f) begin
        if (mon_on && reset === 1'b1) begin
            while (sb.size() > 0 && sb[0].e < edge_cnt) begin
                n_cmp++; n_bad++;
                $display("FAIL missed_word: got no valid_out, expected %h at edge %0d", sb[0].w, sb[0].e);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].e == edge_cnt) begin
                chk("valid_out_pulse", {31'd0, valid_out}, 32'd1);
                chk("data_out_word", data_out, sb[0].w);
                mon_last = sb[0].w;
                got.push_back(data_out);
                void'(sb.pop_front());
            end else begin
                chk("valid_out_idle", {31'd0, valid_out}, 32'd0);
                chk("data_out_hold", data_out, mon_last);
            end
        end
    end

    logic [7:0] a0[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] a1[4] = '{8'h01, 8'h23, 8'h45, 8'h67};

    initial begin
        // Reset then idle
        do_reset();
        idle(5);
        chk("idle_err", {31'd0, err}, 32'd0);

        // Aligned lanes
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, a0[i], 1'b1, a1[i]);
        idle(4);
        chk("aligned_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("aligned_w0", got[0], 32'hDEADBEEF);
            chk("aligned_w1", got[1], 32'h01234567);
        end

        // Gapped lane 0
        do_reset();
        cyc(1'b1, 8'h11, 1'b1, 8'hAA);
        cyc(1'b1, 8'h22, 1'b1, 8'hBB);
        cyc(1'b0, 8'h00, 1'b1, 8'hCC);
        cyc(1'b0, 8'h00, 1'b1, 8'hDD);
        cyc(1'b0, 8'h00, 1'b0, 8'h00);
        cyc(1'b1, 8'h33, 1'b0, 8'h00);
        cyc(1'b1, 8'h44, 1'b0, 8'h00);
        idle(4);
        chk("gapped_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("gapped_w0", got[0], 32'h11223344);
            chk("gapped_w1", got[1], 32'hAABBCCDD);
        end

        // Overflow on lane 1
        do_reset();
        for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1, 8'(8'h10 + i));
        idle(2);
        chk("overflow_err", {31'd0, err}, {31'd0, err_exp()});
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 8'h00);
        idle(4);
        chk("overflow_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("overflow_w0", got[0], 32'hC0C1C2C3);
            chk("overflow_w1", got[1], 32'h10111213);
        end
        chk("overflow_err_sticky", {31'd0, err}, {31'd0, err_exp()});

        // Reset mid-word
        do_reset();
        cyc(1'b1, 8'h12, 1'b0, 8'h00);
        cyc(1'b1, 8'h34, 1'b0, 8'h00);
        do_reset();
        cyc(1'b1, 8'h56, 1'b1, 8'h00);
        cyc(1'b1, 8'h78, 1'b1, 8'h00);
        cyc(1'b1, 8'h9A, 1'b1, 8'h00);
        cyc(1'b1, 8'hBC, 1'b1, 8'h01);
        idle(4);
        chk("midreset_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("midreset_w0", got[0], 32'h56789ABC);
            chk("midreset_w1", got[1], 32'h00000001);
        end

        // Randomised traffic: full rate first, then mixed and skewed lane rates
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            int r0, r1;
            r0 = (blk == 0) ? 100 : int'($urandom_range(0, 100));
            r1 = (blk == 0) ? 100 : int'($urandom_range(0, 100));
            for (int i = 0; i < 250; i++)
                cyc($urandom_range(0, 99) < r0, 8'($urandom), $urandom_range(0, 99) < r1, 8'($urandom));
            if (blk == 0)
                chk("full_rate_no_err", {31'd0, err}, 32'd0);
        end
        idle(8);
        chk("drain_empty", sb.size(), 0);
        chk("random_err", {31'd0, err}, {31'd0, err_exp()});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
